// File: rtl/wb_wport_arbiter.sv
// Register-file write-port arbiter: primary writeback stream has priority, secondary completions queue in a FIFO
// with a starvation counter forcing progress. Define WB_WPORT_ARB_BYPASS_EN for zero-latency secondary bypass.
`ifndef REG_AW
`define REG_AW 5
`endif
`ifndef XLEN
`define XLEN 32
`endif

module wb_wport_arbiter #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               pri_valid,
    output logic               pri_ready,
    input  logic               pri_rd_write,
    input  logic [`REG_AW-1:0] pri_rd_addr,
    input  logic [`XLEN-1:0]   pri_rd_wdata,
    input  logic               sec_valid,
    output logic               sec_ready,
    input  logic [`REG_AW-1:0] sec_rd_addr,
    input  logic [`XLEN-1:0]   sec_rd_wdata,
    output logic               rf_write,
    output logic [`REG_AW-1:0] rf_addr,
    output logic [`XLEN-1:0]   rf_wdata,
    output logic               sec_pending
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [`REG_AW-1:0] q_addr [FIFO_DEPTH];
    logic [`XLEN-1:0]   q_data [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [SW-1:0]      starve_cnt;

    logic pri_use;
    logic force_sec;
    logic pri_grant;
    logic pop;
    logic push;
    logic bypass;

    always_comb begin
        pri_use     = pri_valid & pri_rd_write & (pri_rd_addr != '0);
        sec_pending = (count != '0);
        force_sec   = sec_pending & (starve_cnt == SW'(STARVE_MAX));
        pri_ready   = !force_sec;
        // Grants are qualified by rst_b so entries left over from before a reset never reach the register file.
        pri_grant   = rst_b & pri_use & !force_sec;
        pop         = rst_b & sec_pending & (force_sec | !pri_use);
`ifdef WB_WPORT_ARB_BYPASS_EN
        bypass      = rst_b & !sec_pending & !pri_use & sec_valid;
`else
        bypass      = 1'b0;
`endif
        sec_ready   = (count < CW'(FIFO_DEPTH));
        push        = sec_valid & sec_ready & !bypass;

        rf_write = pri_grant;
        rf_addr  = pri_rd_addr;
        rf_wdata = pri_rd_wdata;
        if (pop) begin
            rf_write = (q_addr[rd_ptr] != '0);
            rf_addr  = q_addr[rd_ptr];
            rf_wdata = q_data[rd_ptr];
        end else if (bypass) begin
            rf_write = (sec_rd_addr != '0);
            rf_addr  = sec_rd_addr;
            rf_wdata = sec_rd_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (push) begin
                q_addr[wr_ptr] <= sec_rd_addr;
                q_data[wr_ptr] <= sec_rd_wdata;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (pop || !sec_pending) begin
                starve_cnt <= '0;
            end else if (starve_cnt != SW'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_wport_arbiter.sv
// Scoreboard bench for wb_wport_arbiter: expected rf writes are queued by the stimulus and
// checked in order by an independent monitor; status outputs are checked at fixed cycles.
module tb_wb_wport_arbiter;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        pri_valid, pri_ready, pri_rd_write;
    logic [4:0]  pri_rd_addr;
    logic [31:0] pri_rd_wdata;
    logic        sec_valid, sec_ready;
    logic [4:0]  sec_rd_addr;
    logic [31:0] sec_rd_wdata;
    logic        rf_write;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic        sec_pending;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [4:0]  sec_a [4];
    logic [31:0] sec_d [4];

    wb_wport_arbiter #(.FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_b(rst_b),
        .pri_valid(pri_valid), .pri_ready(pri_ready), .pri_rd_write(pri_rd_write),
        .pri_rd_addr(pri_rd_addr), .pri_rd_wdata(pri_rd_wdata),
        .sec_valid(sec_valid), .sec_ready(sec_ready),
        .sec_rd_addr(sec_rd_addr), .sec_rd_wdata(sec_rd_wdata),
        .rf_write(rf_write), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .sec_pending(sec_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic sv, input logic [4:0] sa, input logic [31:0] sd);
        pri_valid    = pv;
        pri_rd_write = pw;
        pri_rd_addr  = pa;
        pri_rd_wdata = pd;
        sec_valid    = sv;
        sec_rd_addr  = sa;
        sec_rd_wdata = sd;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back('{a: a, d: d});
    endtask

    // Primary writes x3 every cycle; bit c of force_mask marks a forced secondary cycle,
    // bit c of srdy_mask the expected sec_ready while a secondary request is presented.
    task automatic pri_stream(input int unsigned n, input logic [31:0] force_mask,
                              input logic [31:0] srdy_mask, input int unsigned nsec,
                              input logic [31:0] dbase, input string tag);
        int unsigned p  = 0;
        int unsigned si = 0;
        int unsigned ri = 0;
        for (int unsigned c = 0; c < n; c++) begin
            cyc();
            if (si < nsec) drive(1'b1, 1'b1, 5'd3, dbase + p, 1'b1, sec_a[si], sec_d[si]);
            else           drive(1'b1, 1'b1, 5'd3, dbase + p, 1'b0, 5'd0, 32'd0);
            #1;
            check($sformatf("%s pri_ready c%0d", tag, c), {63'd0, pri_ready}, {63'd0, !force_mask[c]});
            if (si < nsec) begin
                check($sformatf("%s sec_ready c%0d", tag, c), {63'd0, sec_ready}, {63'd0, srdy_mask[c]});
                if (srdy_mask[c]) si++;
            end
            if (force_mask[c]) begin
                expect_wr(sec_a[ri], sec_d[ri]);
                ri++;
            end else begin
                expect_wr(5'd3, dbase + p);
                p++;
            end
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned c = 0; c < n; c++) begin
            cyc();
            drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        end
    endtask

    // Monitor: every rf write is matched in order against the scoreboard queue.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rf_write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got x%0d=%0h expected no write", rf_addr, rf_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("rf_write payload", {27'd0, rf_addr, rf_wdata}, {27'd0, e.a, e.d});
                end
            end
        end
    end

    initial begin
        rst_b = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cyc();
        cyc();
        rst_b = 1'b1;
        #1;
        check("reset sec_pending", {63'd0, sec_pending}, 64'd0);
        check("reset sec_ready",   {63'd0, sec_ready},   64'd1);
        check("reset pri_ready",   {63'd0, pri_ready},   64'd1);
        check("reset rf_write",    {63'd0, rf_write},    64'd0);

        // Idle primary, single secondary request x5=DEADBEEF.
        cyc();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        expect_wr(5'd5, 32'hDEADBEEF);
`ifdef WB_WPORT_ARB_BYPASS_EN
        check("s1 bypass rf_write", {63'd0, rf_write}, 64'd1);
`else
        check("s1 queued rf_write", {63'd0, rf_write}, 64'd0);
`endif
        cyc();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
`ifdef WB_WPORT_ARB_BYPASS_EN
        check("s1 next sec_pending", {63'd0, sec_pending}, 64'd0);
        check("s1 next rf_write",    {63'd0, rf_write},    64'd0);
`else
        check("s1 next sec_pending", {63'd0, sec_pending}, 64'd1);
        check("s1 next rf_write",    {63'd0, rf_write},    64'd1);
`endif
        cyc();
        #1;
        check("s1 drained", {63'd0, sec_pending}, 64'd0);

        // Continuous primary x3 with one secondary x7=0x11: forced at cycle 5.
        sec_a[0] = 5'd7; sec_d[0] = 32'h11;
        pri_stream(7, 32'h0000_0020, 32'hFFFF_FFFF, 1, 32'h300, "s2");
        cyc();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        check("s2 sec_pending", {63'd0, sec_pending}, 64'd0);

        // Three back-to-back secondaries into a depth-2 FIFO under continuous primary.
        sec_a[0] = 5'd10; sec_d[0] = 32'hA0;
        sec_a[1] = 5'd11; sec_d[1] = 32'hB1;
        sec_a[2] = 5'd12; sec_d[2] = 32'hC2;
        pri_stream(17, 32'h0000_8420, 32'hFFFF_FFC3, 3, 32'h400, "s3");
        cyc();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        check("s3 sec_pending", {63'd0, sec_pending}, 64'd0);

        // Non-writing primary lets a queued x9=0x55 through in the same cycle.
        cyc();
        drive(1'b1, 1'b1, 5'd3, 32'h500, 1'b1, 5'd9, 32'h55);
        #1;
        expect_wr(5'd3, 32'h500);
        cyc();
        drive(1'b1, 1'b0, 5'd3, 32'h501, 1'b0, 5'd0, 32'd0);
        #1;
        check("s4 pri_ready", {63'd0, pri_ready}, 64'd1);
        check("s4 rf_write",  {63'd0, rf_write},  64'd1);
        expect_wr(5'd9, 32'h55);
        idle(1);
        #1;
        check("s4 sec_pending", {63'd0, sec_pending}, 64'd0);

        // Address-0 secondary plus primary writing x0: nothing written, entry retired.
        cyc();
        drive(1'b1, 1'b1, 5'd3, 32'h600, 1'b1, 5'd0, 32'h99);
        #1;
        expect_wr(5'd3, 32'h600);
        cyc();
        drive(1'b1, 1'b1, 5'd0, 32'h777, 1'b0, 5'd0, 32'd0);
        #1;
        check("s5 pending before pop", {63'd0, sec_pending}, 64'd1);
        check("s5 rf_write x0 pop",    {63'd0, rf_write},    64'd0);
        cyc();
        #1;
        check("s5 sec_pending",   {63'd0, sec_pending}, 64'd0);
        check("s5 rf_write x0 pri", {63'd0, rf_write},  64'd0);

        // Two queued entries, starve_cnt=3, then a one-cycle reset.
        for (int unsigned c = 0; c < 4; c++) begin
            cyc();
            drive(1'b1, 1'b1, 5'd3, 32'h700 + c, c < 2, 5'd20 + 5'(c), 32'hE0 + c);
            #1;
            expect_wr(5'd3, 32'h700 + c);
        end
        cyc();
        rst_b = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        check("s6 pending pre-reset", {63'd0, sec_pending}, 64'd1);
        check("s6 rf_write in reset", {63'd0, rf_write},    64'd0);
        cyc();
        rst_b = 1'b1;
        #1;
        check("s6 sec_pending", {63'd0, sec_pending}, 64'd0);
        check("s6 sec_ready",   {63'd0, sec_ready},   64'd1);
        check("s6 pri_ready",   {63'd0, pri_ready},   64'd1);
        pri_stream(6, 32'd0, 32'hFFFF_FFFF, 0, 32'h800, "s6");
        idle(4);
        #1;
        check("s6 idle sec_pending", {63'd0, sec_pending}, 64'd0);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_wport_arbiter.md
Name: wb_wport_arbiter

Overview:
- Shares the single register-file write port between two requesters.
  - The in-order pipeline writeback stream (primary).
  - Out-of-band completions from long-latency units such as the divider or CSR/load replay (secondary).
- Secondary writes are held in a small FIFO. The primary has priority.
- A starvation counter guarantees forward progress for the secondary.
- Sits between the writeback stage and the register file.

Parameters:
- FIFO_DEPTH, 2: secondary FIFO entries. Power of two, at least 2.
- STARVE_MAX, 4: number of consecutive cycles a non-empty FIFO may be denied before a forced secondary grant. At least 1.

Ports:
- clk  in  1  core clock
- rst_b  in  1  synchronous active-low reset, sampled on the rising edge of clk
- pri_valid  in  1  primary request valid
- pri_ready  out  1  primary accepted this cycle
- pri_rd_write  in  1  primary intends an rd write
- pri_rd_addr  in  `REG_AW  primary destination register
- pri_rd_wdata  in  `XLEN  primary write data
- sec_valid  in  1  secondary request valid
- sec_ready  out  1  secondary FIFO can accept
- sec_rd_addr  in  `REG_AW  secondary destination register
- sec_rd_wdata  in  `XLEN  secondary write data
- rf_write  out  1  register-file write enable
- rf_addr  out  `REG_AW  register-file write address
- rf_wdata  out  `XLEN  register-file write data
- sec_pending  out  1  FIFO non-empty; used for hazard/stall logic

Behaviour:
- Reset (rst_b=0 at clk edge):
  - FIFO emptied: pointers and count = 0.
  - starve_cnt = 0.
  - Outputs after reset: sec_pending=0, sec_ready=1, pri_ready=1, rf_write=0.
- Reset mid-operation discards all queued secondary writes; no rf_write is produced for them.
- The rf_* outputs are combinational from the current grant, so the write takes effect at the next clk edge.
- Primary "uses port" (pri_use) = pri_valid & pri_rd_write & (pri_rd_addr != 0).
- force_sec = sec_pending & (starve_cnt == STARVE_MAX).
- pri_ready = !force_sec. While pri_ready=0, the primary holds its payload stable.
- Grant per cycle:
  - Primary grant: pri_valid & pri_use & !force_sec. rf_* = primary payload.
  - Secondary grant: sec_pending & (force_sec | !pri_use). Pops the FIFO head.
    - rf_write = (head addr != 0); rf_addr/rf_wdata = head.
    - Address-0 entries are popped silently.
  - No grant: rf_write=0. rf_addr/rf_wdata are don't-care; drive the primary payload.
- A primary with pri_valid=1 and pri_rd_write=0 is accepted (pri_ready=1) and leaves the port to the secondary in the same cycle.
- starve_cnt:
  - Cleared on a pop or when the FIFO is empty.
  - Otherwise, if sec_pending & no pop, incremented, saturating at STARVE_MAX.
- FIFO:
  - sec_ready = (count < FIFO_DEPTH). A full FIFO does not accept, even when popping the same cycle.
  - Push on sec_valid & sec_ready. Simultaneous push and pop keeps count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Entries retire strictly in order.
- Latency: primary 0 cycles (pass-through). Secondary at least 1 cycle from acceptance to rf_write, without the optional bypass.
- Ordering: same-rd ordering between primary and secondary is guaranteed upstream by the scoreboard. The block does no address comparison beyond x0 suppression.

Optional Feature:
- Macro: WB_WPORT_ARB_BYPASS_EN.
- Defined:
  - When the FIFO is empty, !pri_use and sec_valid, the secondary payload drives rf_* in the same cycle. rf_write = (sec_rd_addr != 0).
  - The request is not pushed and sec_ready=1. Secondary latency is 0.
- Undefined:
  - Every secondary request is enqueued. The minimum secondary latency is 1 cycle.

Test Plan:
- Idle primary, sec_valid 1 cycle with addr=5, data=0xDEADBEEF:
  - Without the macro: rf_write=1, addr=5, data=0xDEADBEEF one cycle later.
  - With the macro: same write in the same cycle; sec_pending stays 0.
- Primary writes x3 every cycle while the secondary enqueues x7=0x11:
  - Primary writes x3 for 4 cycles.
  - 5th cycle: pri_ready=0 and rf writes x7=0x11.
  - Next cycle: primary resumes; starve_cnt=0.
- Secondary pushes 3 back-to-back while the primary writes continuously (FIFO_DEPTH=2):
  - sec_ready drops to 0 after 2 pushes.
  - Third request held until the forced pop.
  - Entries retire in push order.
- Primary pri_valid=1, pri_rd_write=0, FIFO holding x9=0x55:
  - pri_ready=1; rf writes x9=0x55 the same cycle.
- Secondary entry with addr=0 queued, plus primary writing x0:
  - rf_write stays 0 throughout; the entry is popped and sec_pending returns to 0.
- FIFO holding 2 entries, starve_cnt=3, rst_b=0 for 1 cycle:
  - sec_pending=0, sec_ready=1, starve_cnt=0.
  - No rf_write from the stale entries afterwards.
